// File: rtl/writeback_buffer.sv
// Write-back buffer: merges ALU and load results into an in-order queue that
// drains one entry per cycle into the register file's single write port, with bypass lookups.
module writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [W-1:0]             alu_inf,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_rd,
  input  logic [W-1:0]             mem_inf,
  output logic                     mem_ready,
  output logic                     wb_we,
  output logic [4:0]               wb_rd,
  output logic [W-1:0]             wb_inf,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [W-1:0]             fwd1,
  output logic [W-1:0]             fwd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]   rd;
    logic [W-1:0] inf;
  } entry_t;

  entry_t          queue [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic            full;
  logic            alu_push;
  logic            mem_push;
  logic            push;
  logic            pop;
  logic            enq;
  entry_t          push_entry;

  assign full = (count == (AW+1)'(DEPTH));

  // x0 requests are always accepted (and dropped), so they never depend on queue space.
  assign alu_ready = !reset && ((alu_rd == 5'd0) || !full);
  assign mem_ready = !reset && ((mem_rd == 5'd0) ||
                                (!full && !(alu_valid && (alu_rd != 5'd0))));

  assign alu_push   = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign mem_push   = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign push       = alu_push || mem_push;
  assign push_entry = alu_push ? entry_t'{alu_rd, alu_inf} : entry_t'{mem_rd, mem_inf};
  assign pop        = (count != '0);
  // An empty queue forwards the push straight into the wb stage instead of enqueuing it.
  assign enq        = push && pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      wb_we  <= 1'b0;
      wb_rd  <= '0;
      wb_inf <= '0;
    end else begin
      if (pop) begin
        wb_we  <= 1'b1;
        wb_rd  <= queue[head].rd;
        wb_inf <= queue[head].inf;
        head   <= head + 1'b1;
      end else if (push) begin
        wb_we  <= 1'b1;
        wb_rd  <= push_entry.rd;
        wb_inf <= push_entry.inf;
      end else begin
        wb_we  <= 1'b0;
      end
      if (enq) tail <= tail + 1'b1;
      if (enq && !pop)      count <= count + 1'b1;
      else if (!enq && pop) count <= count - 1'b1;
    end
  end

  // NOTE: queue storage has no reset; count/head/tail define which slots are valid.
  always_ff @(posedge clock) begin
    if (!reset && enq) queue[tail] <= push_entry;
  end

  // Oldest-to-youngest scan so the youngest match overrides; wb stage is the oldest of all.
  always_comb begin
    logic [AW-1:0] idx;
    hit1 = 1'b0;
    fwd1 = '0;
    hit2 = 1'b0;
    fwd2 = '0;
    if (wb_we && (rs1 != 5'd0) && (wb_rd == rs1)) begin
      hit1 = 1'b1;
      fwd1 = wb_inf;
    end
    if (wb_we && (rs2 != 5'd0) && (wb_rd == rs2)) begin
      hit2 = 1'b1;
      fwd2 = wb_inf;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (((AW+1)'(i) < count) && (rs1 != 5'd0) && (queue[idx].rd == rs1)) begin
        hit1 = 1'b1;
        fwd1 = queue[idx].inf;
      end
      if (((AW+1)'(i) < count) && (rs2 != 5'd0) && (queue[idx].rd == rs2)) begin
        hit2 = 1'b1;
        fwd2 = queue[idx].inf;
      end
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model of pending register writes.
module tb_writeback_buffer;

  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          alu_valid, mem_valid;
  logic [4:0]    alu_rd, mem_rd, rs1, rs2;
  logic [W-1:0]  alu_inf, mem_inf;
  logic          alu_ready, mem_ready, wb_we, hit1, hit2;
  logic [4:0]    wb_rd;
  logic [W-1:0]  wb_inf, fwd1, fwd2;
  logic [$clog2(DEPTH):0] count;

  writeback_buffer #(.DEPTH(DEPTH), .W(W)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_inf(alu_inf), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_inf(mem_inf), .mem_ready(mem_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_inf(wb_inf),
    .rs1(rs1), .rs2(rs2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]   rd;
    logic [W-1:0] inf;
  } write_t;

  // Reference model: accepted writes not yet on the write port, plus the write port itself.
  write_t        pending[$];
  logic          m_we;
  logic [4:0]    m_rd;
  logic [W-1:0]  m_inf;
  logic          alu_acc, mem_acc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] lookup(input logic [4:0] rs);
    if (rs == 5'd0) return '0;
    for (int i = pending.size() - 1; i >= 0; i--)
      if (pending[i].rd == rs) return {1'b1, pending[i].inf};
    if (m_we && m_rd == rs) return {1'b1, m_inf};
    return '0;
  endfunction

  // Drive one cycle of inputs, check every output against the model, then advance one edge.
  task automatic step(input logic r,
                      input logic av, input logic [4:0] ard, input logic [W-1:0] ainf,
                      input logic mv, input logic [4:0] mrd, input logic [W-1:0] minf,
                      input logic [4:0] s1, input logic [4:0] s2);
    logic        full, e_ar, e_mr, has_push;
    logic [W:0]  l1, l2;
    write_t      pw;
    reset = r; alu_valid = av; alu_rd = ard; alu_inf = ainf;
    mem_valid = mv; mem_rd = mrd; mem_inf = minf; rs1 = s1; rs2 = s2;
    #3;
    full = (pending.size() == DEPTH);
    e_ar = !r && (ard == 5'd0 || !full);
    e_mr = !r && (mrd == 5'd0 || (!full && !(av && ard != 5'd0)));
    l1 = lookup(s1);
    l2 = lookup(s2);
    check("alu_ready", 64'(alu_ready), 64'(e_ar));
    check("mem_ready", 64'(mem_ready), 64'(e_mr));
    check("count",     64'(count),     64'(pending.size()));
    check("wb_we",     64'(wb_we),     64'(m_we));
    check("wb_rd",     64'(wb_rd),     64'(m_rd));
    check("wb_inf",    64'(wb_inf),    64'(m_inf));
    check("hit1",      64'(hit1),      64'(l1[W]));
    check("fwd1",      64'(fwd1),      64'(l1[W-1:0]));
    check("hit2",      64'(hit2),      64'(l2[W]));
    check("fwd2",      64'(fwd2),      64'(l2[W-1:0]));
    alu_acc = av && e_ar;
    mem_acc = mv && e_mr;
    has_push = 1'b0;
    pw = '{rd: 5'd0, inf: '0};
    if (alu_acc && ard != 5'd0) begin
      has_push = 1'b1; pw = '{rd: ard, inf: ainf};
    end else if (mem_acc && mrd != 5'd0) begin
      has_push = 1'b1; pw = '{rd: mrd, inf: minf};
    end
    if (r) begin
      pending.delete();
      m_we = 1'b0; m_rd = '0; m_inf = '0;
    end else if (pending.size() > 0) begin
      write_t h;
      h = pending.pop_front();
      m_we = 1'b1; m_rd = h.rd; m_inf = h.inf;
      if (has_push) pending.push_back(pw);
    end else if (has_push) begin
      m_we = 1'b1; m_rd = pw.rd; m_inf = pw.inf;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    step(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, s1, s2);
  endtask

  logic          av, mv;
  logic [4:0]    ard, mrd;
  logic [W-1:0]  ainf, minf;

  initial begin
    reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    alu_rd = '0; mem_rd = '0; alu_inf = '0; mem_inf = '0; rs1 = '0; rs2 = '0;
    alu_acc = 1'b0; mem_acc = 1'b0;
    m_we = 1'b0; m_rd = '0; m_inf = '0;
    @(posedge clock);
    @(posedge clock);
    #1;

    // Reset held: readiness low, outputs at reset values.
    step(1'b1, 1'b1, 5'd2, 32'h5, 1'b1, 5'd3, 32'h6, 5'd2, 5'd3);

    // Single write.
    step(1'b0, 1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, '0, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    idle(5'd5, 5'd0);

    // Simultaneous producers: ALU wins, mem follows next cycle.
    step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd3, 5'd4);
    step(1'b0, 1'b0, 5'd0, '0,     1'b1, 5'd4, 32'h22, 5'd3, 5'd4);
    idle(5'd3, 5'd4);
    idle(5'd3, 5'd4);

    // x0 drop does not block mem.
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd7, 32'h77, 5'd7, 5'd0);
    idle(5'd7, 5'd0);
    idle(5'd7, 5'd0);

    // Back-to-back same rd: bypass must follow the youngest write.
    step(1'b0, 1'b1, 5'd9, 32'h1, 1'b0, 5'd0, '0, 5'd9, 5'd0);
    step(1'b0, 1'b1, 5'd9, 32'h2, 1'b0, 5'd0, '0, 5'd9, 5'd0);
    idle(5'd9, 5'd0);
    idle(5'd9, 5'd0);

    // Stream of six ALU writes, then reset mid-stream.
    for (int i = 1; i <= 6; i++)
      step(1'b0, 1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0, '0, 5'(i), 5'(i - 1));
    step(1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd10, 32'hA0, 5'd8, 5'd6);
    step(1'b1, 1'b1, 5'd11, 32'hB0, 1'b1, 5'd12, 32'hC0, 5'd8, 5'd10);
    idle(5'd8, 5'd10);
    idle(5'd11, 5'd12);

    // Randomized traffic; producers hold their request until it is accepted.
    av = 1'b0; mv = 1'b0; ard = '0; mrd = '0; ainf = '0; minf = '0;
    for (int c = 0; c < 2000; c++) begin
      logic r;
      if (!(av && !alu_acc)) begin
        av   = ($urandom_range(0, 99) < 60);
        ard  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
        ainf = $urandom;
      end
      if (!(mv && !mem_acc)) begin
        mv   = ($urandom_range(0, 99) < 50);
        mrd  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
        minf = $urandom;
      end
      r = ($urandom_range(0, 99) < 3);
      step(r, av, ard, ainf, mv, mrd, minf,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(5'd1, 5'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
